// File: rtl/corr_pkg.sv
// Shared constants, FSM states and FIFO entry layout for the correlator readout.
// Used by corr_readout and corr_rd_fifo.
package corr_pkg;

    localparam int AW   = 9;
    localparam int DW   = 32;
    localparam int BINS = 1 << AW;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        ARM,
        SWEEP,
        DRAIN,
        RELEASE,
        CLEAR,
        FIN
    } state_e;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } fifo_entry_t;

endpackage

// File: rtl/corr_rd_fifo.sv
// Small synchronous FIFO holding bank read results until the stream accepts them.
// Synchronous active-low reset empties it; storage itself is not cleared.
module corr_rd_fifo
#(
    parameter int DEPTH = 4,
    parameter int W     = 41,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/corr_readout.sv
// Readout stage: freezes the MAC bank, sweeps all bins and streams the sums out.
// Define CORR_READOUT_AUTOCLR_EN to clear the bank after each readout.
module corr_readout
    import corr_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int FIFO_D = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          hold,
    input  logic          hold_ack,
    output logic          mac_read,
    output logic [AW-1:0] mac_raddr,
    input  logic [DW-1:0] mac_rdata,
    output logic          mac_clr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int CW = $clog2(FIFO_D + 1);
    localparam int IW = AW + 1;

    state_e            state_q, state_d;
    logic [IW-1:0]     cnt_q, cnt_d;
    logic [RD_LAT-1:0] tag_q, tag_d;
    logic [AW-1:0]     taddr_q [RD_LAT];
    logic [AW-1:0]     taddr_d [RD_LAT];

    logic        issue;
    logic [31:0] occ;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;
    fifo_entry_t push_entry;
    fifo_entry_t head;

    // Credits: stored entries plus reads still in the bank pipeline.
    always_comb begin
        occ = 32'(fifo_count);
        for (int i = 0; i < RD_LAT; i++) begin
            occ = occ + 32'(tag_q[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        issue     = 1'b0;
        mac_read  = 1'b0;
        mac_raddr = '0;
        mac_clr   = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_ack) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                mac_read = 1'b1;
                state_d  = SWEEP;
            end
            SWEEP: begin
                mac_read  = 1'b1;
                mac_raddr = cnt_q[AW-1:0];
                if (occ < 32'(FIFO_D)) begin
                    issue = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == IW'(BINS - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                mac_read = 1'b1;
                if (tag_q == '0) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                cnt_d = '0;
`ifdef CORR_READOUT_AUTOCLR_EN
                state_d = CLEAR;
`else
                state_d = FIN;
`endif
            end
            CLEAR: begin
`ifdef CORR_READOUT_AUTOCLR_EN
                // Bank needs BINS+2 cycles to walk its clear pass.
                mac_clr = (cnt_q == '0);
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == IW'(BINS + 1)) begin
                    state_d = FIN;
                end
`else
                state_d = FIN;
`endif
            end
            FIN: begin
                if (fifo_empty) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tag_d[0]   = issue;
        taddr_d[0] = cnt_q[AW-1:0];
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i]   = tag_q[i-1];
            taddr_d[i] = taddr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                taddr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            for (int i = 0; i < RD_LAT; i++) begin
                taddr_q[i] <= taddr_d[i];
            end
        end
    end

    assign push            = tag_q[RD_LAT-1];
    assign push_entry.data = mac_rdata;
    assign push_entry.addr = taddr_q[RD_LAT-1];

    corr_rd_fifo #(
        .DEPTH (FIFO_D),
        .W     ($bits(fifo_entry_t)),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? head.data : '0;
    assign out_addr  = out_valid ? head.addr : '0;
    assign out_last  = out_valid & (head.addr == AW'(BINS - 1));
    assign hold      = (state_q != IDLE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_corr_readout.sv
// Directed bench for corr_readout with a behavioural 2-cycle-latency bank model.
module tb_corr_readout;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        hold;
    logic        hold_ack;
    logic        mac_read;
    logic [8:0]  mac_raddr;
    logic [31:0] mac_rdata;
    logic        mac_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [8:0]  out_addr;
    logic        out_last;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    corr_readout dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .hold      (hold),
        .hold_ack  (hold_ack),
        .mac_read  (mac_read),
        .mac_raddr (mac_raddr),
        .mac_rdata (mac_rdata),
        .mac_clr   (mac_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank: ram[i] = 3*i until a clear pulse arrives after the last reload.
    int          zero_mark = 0;
    int          clr_cnt   = 0;
    logic [31:0] r1, r2;
    always @(posedge clk) begin
        r1 <= (clr_cnt > zero_mark) ? 32'd0 : 32'(mac_raddr) * 32'd3;
        r2 <= r1;
    end
    assign mac_rdata = r2;

    logic [31:0] q_data [$];
    logic [8:0]  q_addr [$];
    logic        q_last [$];
    int          q_cyc  [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          arm_cyc  = 0;
    int          fall_cyc = 0;
    int          clr_cyc  = 0;
    int          max_cnt  = 0;
    logic        rd_prev  = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_addr.push_back(out_addr);
                q_last.push_back(out_last);
                q_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mac_read && !rd_prev) arm_cyc = cyc;
            if (!mac_read && rd_prev) fall_cyc = cyc;
            if (mac_clr) begin
                clr_cnt++;
                clr_cyc = cyc;
            end
            if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
        end
        rd_prev = mac_read;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int stream_errs(input int base, input bit zero);
        int e = 0;
        for (int i = 0; i < 512; i++) begin
            logic [31:0] ed;
            logic [8:0]  ea;
            ed = zero ? 32'd0 : 32'(i * 3);
            ea = 9'(i);
            if (base + i >= q_addr.size()) e++;
            else if (q_addr[base+i] !== ea || q_data[base+i] !== ed ||
                     q_last[base+i] !== (i == 511)) e++;
        end
        return e;
    endfunction

    task automatic start_run(input bit reload);
        if (reload) zero_mark = clr_cnt;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        hold_ack = 1'b1;
    endtask

    task automatic finish_run(input int mode, input int dbase);
        int n = 0;
        while (done_cnt == dbase && n < 20000) begin
            out_ready = (mode == 1) ? ($urandom_range(0, 9) < 3) : 1'b1;
            step(1);
            n++;
        end
        total++;
        if (n >= 20000) begin
            bad++;
            $display("FAIL run_timeout: cycles=%0d limit=20000", n);
        end
        hold_ack  = 1'b0;
        out_ready = 1'b1;
        step(3);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(2);
        total++;
        if ({hold, mac_read, mac_raddr, mac_clr, out_valid, out_data, out_addr,
             out_last, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%0b valid=%0b read=%0b req=0",
                     busy, out_valid, mac_read);
        end
        rst_n = 1'b1;
        step(2);
        total++;
        if (busy !== 1'b0 || hold !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%0b hold=%0b req=0", busy, hold);
        end
    endtask

    task automatic test_basic;
        int base  = q_addr.size();
        int dbase = done_cnt;
        int e;
        start_run(1'b1);
        total++;
        if (hold !== 1'b1 || mac_read !== 1'b0) begin
            bad++;
            $display("FAIL basic_hold: hold=%0b read=%0b req=1/0", hold, mac_read);
        end
        finish_run(0, dbase);
        total++;
        if (q_addr.size() - base !== 512) begin
            bad++;
            $display("FAIL basic_count: beats=%0d req=512", q_addr.size() - base);
        end
        e = stream_errs(base, 1'b0);
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL basic_stream: bad_beats=%0d req=0", e);
        end
        total++;
        if (q_cyc.size() > base && q_cyc[base] < arm_cyc + 3) begin
            bad++;
            $display("FAIL basic_latency: first=%0d req>=%0d", q_cyc[base], arm_cyc + 3);
        end
        total++;
        if (done_cnt - dbase !== 1 || busy !== 1'b0 || hold !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: pulses=%0d busy=%0b req=1/0", done_cnt - dbase, busy);
        end
    endtask

    task automatic test_random_ready;
        int base  = q_addr.size();
        int dbase = done_cnt;
        int e;
        start_run(1'b1);
        finish_run(1, dbase);
        e = stream_errs(base, 1'b0);
        total++;
        if (q_addr.size() - base !== 512 || e !== 0) begin
            bad++;
            $display("FAIL random_stream: beats=%0d bad_beats=%0d req=512/0",
                     q_addr.size() - base, e);
        end
        total++;
        if (max_cnt > 4) begin
            bad++;
            $display("FAIL random_fifo_max: max=%0d req<=4", max_cnt);
        end
    endtask

    task automatic test_stall;
        int base  = q_addr.size();
        int dbase = done_cnt;
        int n     = 0;
        int e     = 0;
        start_run(1'b1);
        while (!(out_valid && out_addr == 9'd200) && n < 5000) begin
            step(1);
            n++;
        end
        out_ready = 1'b0;
        total++;
        if (n >= 5000) begin
            bad++;
            $display("FAIL stall_reach: cycles=%0d req<5000", n);
        end
        step(10);
        total++;
        if (mac_raddr !== 9'd204 || mac_read !== 1'b1) begin
            bad++;
            $display("FAIL stall_raddr: raddr=%0d read=%0b req=204/1", mac_raddr, mac_read);
        end
        for (int i = 0; i < 90; i++) begin
            if (mac_raddr !== 9'd204 || out_valid !== 1'b1 || out_addr !== 9'd200 ||
                out_data !== 32'd600 || out_last !== 1'b0) e++;
            step(1);
        end
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL stall_stable: bad_cycles=%0d req=0", e);
        end
        finish_run(0, dbase);
        e = stream_errs(base, 1'b0);
        total++;
        if (q_addr.size() - base !== 512 || e !== 0) begin
            bad++;
            $display("FAIL stall_stream: beats=%0d bad_beats=%0d req=512/0",
                     q_addr.size() - base, e);
        end
    endtask

    task automatic test_ignore_start;
        int base  = q_addr.size();
        int dbase = done_cnt;
        int n     = 0;
        int e;
        start_run(1'b1);
        while (!(mac_read && mac_raddr == 9'd50) && n < 2000) begin
            step(1);
            n++;
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        finish_run(0, dbase);
        e = stream_errs(base, 1'b0);
        total++;
        if (q_addr.size() - base !== 512 || e !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start: beats=%0d bad_beats=%0d busy=%0b req=512/0/0",
                     q_addr.size() - base, e, busy);
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(50);
        total++;
        if (hold !== 1'b1 || busy !== 1'b1 || mac_read !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_wait: hold=%0b busy=%0b read=%0b req=1/1/0",
                     hold, busy, mac_read);
        end
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset_mid;
        int n = 0;
        int base;
        int dbase;
        int e;
        start_run(1'b1);
        while (!(mac_read && mac_raddr == 9'd300) && n < 3000) begin
            step(1);
            n++;
        end
        rst_n = 1'b0;
        step(1);
        total++;
        if ({hold, mac_read, mac_raddr, mac_clr, out_valid, out_data, out_addr,
             out_last, busy, done} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: busy=%0b valid=%0b read=%0b raddr=%0d req=0",
                     busy, out_valid, mac_read, mac_raddr);
        end
        rst_n    = 1'b1;
        hold_ack = 1'b0;
        step(2);
        base  = q_addr.size();
        dbase = done_cnt;
        start_run(1'b1);
        finish_run(0, dbase);
        e = stream_errs(base, 1'b0);
        total++;
        if (q_addr.size() - base !== 512 || e !== 0) begin
            bad++;
            $display("FAIL midreset_stream: beats=%0d bad_beats=%0d req=512/0",
                     q_addr.size() - base, e);
        end
    endtask

`ifdef CORR_READOUT_AUTOCLR_EN
    task automatic test_autoclr;
        int base  = q_addr.size();
        int dbase = done_cnt;
        int cbase = clr_cnt;
        int e;
        start_run(1'b1);
        finish_run(0, dbase);
        total++;
        if (clr_cnt - cbase !== 1 || clr_cyc <= fall_cyc) begin
            bad++;
            $display("FAIL clr_pulse: pulses=%0d clr=%0d fall=%0d req=1",
                     clr_cnt - cbase, clr_cyc, fall_cyc);
        end
        total++;
        if (done_cyc - clr_cyc < 514) begin
            bad++;
            $display("FAIL clr_done_gap: gap=%0d req>=514", done_cyc - clr_cyc);
        end
        base  = q_addr.size();
        dbase = done_cnt;
        start_run(1'b0);
        finish_run(0, dbase);
        e = stream_errs(base, 1'b1);
        total++;
        if (q_addr.size() - base !== 512 || e !== 0) begin
            bad++;
            $display("FAIL clr_zero_stream: beats=%0d bad_beats=%0d req=512/0",
                     q_addr.size() - base, e);
        end
    endtask
`else
    task automatic test_autoclr;
        total++;
        if (clr_cnt !== 0) begin
            bad++;
            $display("FAIL no_clr: pulses=%0d req=0", clr_cnt);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        hold_ack  = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_random_ready();
        test_stall();
        test_ignore_start();
        test_reset_mid();
        test_autoclr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/corr_readout.md
Name: corr_readout

Overview:
- Downstream readout stage for the 512-bin RAM MAC correlator bank.
- On request, freezes sampling, sweeps the bank's read port over bins 0..2**AW-1 and streams the 32-bit sums out on a valid/ready interface, with per-bin address and last flag.
- Absorbs the bank's fixed read latency with a credit-controlled output FIFO; backpressure never loses data.

Parameters:
- AW, 9, bank address width; bins = 2**AW.
- DW, 32, bank data width.
- RD_LAT, 2, cycles from rAddr presented (bank in read state) to valid rData.
- FIFO_D, 4, output FIFO depth; must be >= RD_LAT+1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle readout request; ignored unless idle.
- hold  out  1  request to upstream feeder to stop issuing sin.
- hold_ack  in  1  upstream confirms no MAC pass in flight and sin suppressed.
- mac_read  out  1  to bank read.
- mac_raddr  out  AW  to bank rAddr.
- mac_rdata  in  DW  from bank rData.
- mac_clr  out  1  to bank clr; one-cycle pulse.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  DW  bin sum.
- out_addr  out  AW  bin index of out_data.
- out_last  out  1  high with bin 2**AW-1.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the sequence completes.

Behaviour:
- Interface: single clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n low at clock edge): all outputs 0; FSM=IDLE; FIFO, issue counter and pipeline tags cleared. Applies mid-sequence too. The bank must be reset together or left to time out; mac_read low returns it to wait.
- IDLE: start -> HOLD; hold=1 from next cycle.
- HOLD: hold=1; wait for hold_ack=1, then -> ARM.
- ARM (1 cycle): mac_read=1, mac_raddr=0; bank enters read state at this edge. -> SWEEP.
- SWEEP: mac_read=1.
  - Issue bin k (mac_raddr=k, tag shift-in=1) only when fifo_count + inflight < FIFO_D; otherwise hold mac_raddr and shift in tag=0.
  - Tag pipe is RD_LAT deep. When a tag=1 exits, push {mac_rdata, its addr} into the FIFO.
  - After issuing bin 2**AW-1 -> DRAIN. Issue counter is AW+1 bits; no wrap past the last bin.
- DRAIN: mac_read=1 until the tag pipe is empty, then -> RELEASE.
- RELEASE (1 cycle): mac_read=0; bank returns to wait. -> CLEAR with the optional feature, else -> FIN.
- FIN: wait until the FIFO is empty and the last beat has been accepted. Then done=1 for one cycle, hold=0, -> IDLE.
- Stream: out_valid = FIFO not empty. A beat transfers when out_valid & out_ready. Data, addr and last are stable while valid is high and ready is low. A push and a pop in the same cycle are legal; count unchanged.
- Ordering: exactly 2**AW beats, addresses 0..2**AW-1 in order, out_last only on the final one.
- Simultaneous events:
  - start outside IDLE is ignored.
  - hold_ack dropping after HOLD is ignored; upstream owns that protocol.
- hold stays 1 from HOLD entry to the done cycle inclusive.

Optional Feature:
- Macro: CORR_READOUT_AUTOCLR_EN.
- Defined:
  - RELEASE -> CLEAR. CLEAR pulses mac_clr=1 in its first cycle, then counts 2**AW+2 cycles to cover the bank's clear pass.
  - Then -> FIN. The FIFO may drain concurrently. done is asserted only after both the clear count and the drain complete.
- Undefined: mac_clr is tied 0, there is no CLEAR state, and sums accumulate across readouts.

Decomposition:
- Package corr_pkg:
  - constants AW, DW, bin count;
  - FSM state enum {IDLE, HOLD, ARM, SWEEP, DRAIN, RELEASE, CLEAR, FIN};
  - FIFO entry struct {data, addr}.
- One sub-module: corr_rd_fifo.
  - Synchronous FIFO, FIFO_D entries wide enough for DW+AW, with count output.
  - Same clock and synchronous active-low reset.

Test Plan:
- Bank preloaded with ram[i]=i*3; start; hold_ack after 5 cycles; out_ready=1 -> 512 beats. out_data=3*addr, addr 0..511, out_last only at 511, done pulse; first beat no earlier than ARM+1+RD_LAT.
- Same preload, out_ready toggled by random 30% duty -> identical 512-beat sequence; no drops or duplicates; fifo_count never exceeds 4.
- out_ready=0 for 100 cycles mid-sweep at bin 200 -> mac_raddr frozen; out_valid held with addr 200 stable; after release, stream resumes at 200.
- start during SWEEP and hold_ack never asserted in a second run -> second start ignored; FSM waits in HOLD with mac_read=0.
- rst_n low for 1 cycle at bin 300 -> all outputs 0 next cycle; a new start gives a full 0..511 readout.
- With CORR_READOUT_AUTOCLR_EN defined -> mac_clr single pulse after mac_read falls; a subsequent readout returns all zeros; done comes no earlier than 514 cycles after the clr pulse.
